sw_input_port: RTL



---
 rtl/swin_pkg.sv | 56 +++++
 rtl/swin_evt_fifo.sv | 92 +++++++++
 rtl/sw_input_port.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/swin_pkg.sv
// ============================================================================
//  Module      : swin_pkg
//  Description : Shared constants and types for the switch input port:
//                register indices, STATUS/CTRL bit positions, event layout.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package swin_pkg;

    // Word register indices on the MIO read/write path
    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_EVENT  = 2'd2;
    localparam logic [1:0] ADDR_CTRL   = 2'd3;

    // STATUS register bit positions
    localparam int c_stat_empty   = 0;
    localparam int c_stat_full    = 1;
    localparam int c_stat_ovf     = 2;
    localparam int c_stat_cnt_lsb = 4;
    localparam int c_stat_cnt_w   = 4;

    // CTRL register bit positions
    localparam int c_ctrl_clr_ovf = 0;
    localparam int c_ctrl_flush   = 1;

    // Event word layout: changed mask in the upper half, new level in the lower
    localparam int c_evt_mask_w = 16;
    localparam int c_evt_data_w = 16;
    localparam int c_evt_w      = c_evt_mask_w + c_evt_data_w;

    typedef struct packed {
        logic [c_evt_mask_w-1:0] mask;
        logic [c_evt_data_w-1:0] data;
    } swin_evt_t;

    // Assemble the STATUS word; unused bits read as zero
    function automatic logic [31:0] swin_status(
        input logic                    empty,
        input logic                    full,
        input logic                    ovf,
        input logic [c_stat_cnt_w-1:0] cnt
    );
        logic [31:0] s;
        s                                   = '0;
        s[c_stat_empty]                     = empty;
        s[c_stat_full]                      = full;
        s[c_stat_ovf]                       = ovf;
        s[c_stat_cnt_lsb +: c_stat_cnt_w]   = cnt;
        return s;
    endfunction

endpackage

`default_nettype wire

// File: rtl/swin_evt_fifo.sv
// ============================================================================
//  Module      : swin_evt_fifo
//  Description : Small synchronous FIFO for switch-change events. Supports
//                push, pop and flush; a push and a pop in the same cycle both
//                take effect even when full. A push that cannot be accepted
//                is reported on o_drop.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module swin_evt_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_drop
);

    localparam int                c_aw       = $clog2(DEPTH);
    localparam int                c_cw       = c_aw + 1;
    localparam logic [c_aw-1:0]   c_ptr_one  = c_aw'(1);
    localparam logic [c_cw-1:0]   c_cnt_one  = c_cw'(1);
    localparam logic [c_cw-1:0]   c_full_cnt = c_cw'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_cw-1:0]  r_count;

    logic w_empty;
    logic w_full;
    logic w_pop_ok;
    logic w_push_ok;

    // Occupancy flags and accepted push/pop; a pop frees room for a push when full
    always_comb begin
        w_empty   = (r_count == '0);
        w_full    = (r_count == c_full_cnt);
        w_pop_ok  = i_pop & ~w_empty;
        w_push_ok = i_push & (~w_full | w_pop_ok);
    end

    assign o_drop  = i_push & w_full & ~w_pop_ok;
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rd_ptr];

    // Pointers and count; flush overrides any push or pop in the same cycle
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage write; contents need no reset because count gates visibility
    always_ff @(posedge clk) begin
        if (rstn && w_push_ok && !i_flush) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

endmodule

`default_nettype wire

// File: rtl/sw_input_port.sv
// ============================================================================
//  Module      : sw_input_port
//  Description : Memory-mapped switch input peripheral. Synchronizes and
//                debounces sw_i, queues every change of the debounced vector
//                as an event, and exposes DATA/STATUS/EVENT/CTRL registers on
//                the MIO read path.
//                Optional macro SWIN_IRQ_EN: registered event-pending irq;
//                when undefined irq is tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sw_input_port
    import swin_pkg::*;
#(
    parameter int N_SW       = 16,
    parameter int DB_CYCLES  = 1000000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [N_SW-1:0] sw_i,
    input  logic            cs,
    input  logic [1:0]      addr,
    input  logic            we,
    input  logic            rd,
    input  logic [31:0]     wdata,
    output logic [31:0]     rdata,
    output logic            irq
);

    localparam int                    c_tick_w    = $clog2(DB_CYCLES);
    localparam logic [c_tick_w-1:0]   c_tick_last = c_tick_w'(DB_CYCLES - 1);
    localparam logic [c_tick_w-1:0]   c_tick_one  = c_tick_w'(1);
    localparam int                    c_cnt_w     = $clog2(FIFO_DEPTH) + 1;

    // Input conditioning state
    logic [N_SW-1:0]     r_sync1;
    logic [N_SW-1:0]     r_sync2;
    logic [N_SW-1:0]     r_sample;
    logic [N_SW-1:0]     r_deb;
    logic [c_tick_w-1:0] r_tick_cnt;
    logic                r_ovf;

    logic                w_tick;
    logic [N_SW-1:0]     w_agree;
    logic [N_SW-1:0]     w_deb_next;
    logic [N_SW-1:0]     w_chg;
    logic                w_push;
    swin_evt_t           w_evt;

    // Bus decode
    logic                w_rd_evt;
    logic                w_wr_ctrl;
    logic                w_flush;
    logic                w_clr_ovf;

    // FIFO view
    logic [c_evt_w-1:0]      w_head;
    logic                    w_full;
    logic                    w_empty;
    logic [c_cnt_w-1:0]      w_count;
    logic                    w_drop;
    logic [c_stat_cnt_w-1:0] w_cnt4;

    // Only the two CTRL command bits carry meaning in a write
    logic w_unused_wdata;
    assign w_unused_wdata = &{1'b0, wdata[31:2]};

    // Two-flop synchronizer for the asynchronous switch levels
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= sw_i;
            r_sync2 <= r_sync1;
        end
    end

    assign w_tick = (r_tick_cnt == c_tick_last);

    // Free-running sample-tick divider, wraps at DB_CYCLES-1
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + c_tick_one;
        end
    end

    // A bit is accepted only when two consecutive ticks see the same level
    always_comb begin
        w_agree    = ~(r_sync2 ^ r_sample);
        w_deb_next = r_deb;
        if (w_tick) begin
            w_deb_next = (r_deb & ~w_agree) | (r_sample & w_agree);
        end
        w_chg = r_deb ^ w_deb_next;
    end

    // Tick sample register and debounced vector
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_sample <= '0;
            r_deb    <= '0;
        end else begin
            if (w_tick) begin
                r_sample <= r_sync2;
            end
            r_deb <= w_deb_next;
        end
    end

    // Event word for the cycle the debounced vector changes
    always_comb begin
        w_evt                 = '0;
        w_evt.mask[N_SW-1:0]  = w_chg;
        w_evt.data[N_SW-1:0]  = w_deb_next;
    end

    assign w_push = |w_chg;

    // CPU strobes only count when the port is selected
    always_comb begin
        w_rd_evt  = cs & rd & (addr == ADDR_EVENT);
        w_wr_ctrl = cs & we & (addr == ADDR_CTRL);
        w_flush   = w_wr_ctrl & wdata[c_ctrl_flush];
        w_clr_ovf = w_wr_ctrl & wdata[c_ctrl_clr_ovf];
    end

    swin_evt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (c_evt_w)
    ) u_evt_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .i_push  (w_push),
        .i_wdata (w_evt),
        .i_pop   (w_rd_evt),
        .i_flush (w_flush),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count),
        .o_drop  (w_drop)
    );

    // Sticky overflow; a new drop beats a same-cycle clear
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (w_clr_ovf) begin
            r_ovf <= 1'b0;
        end
    end

    // Fit the FIFO occupancy into the 4-bit STATUS count field
    always_comb begin
        w_cnt4 = '0;
        for (int i = 0; (i < c_cnt_w) && (i < c_stat_cnt_w); i++) begin
            w_cnt4[i] = w_count[i];
        end
    end

    // Read mux, purely a function of addr and current state
    always_comb begin
        rdata = '0;
        case (addr)
            ADDR_DATA:   rdata[N_SW-1:0] = r_deb;
            ADDR_STATUS: rdata = swin_status(w_empty, w_full, r_ovf, w_cnt4);
            ADDR_EVENT:  rdata = w_empty ? '0 : w_head;
            ADDR_CTRL:   rdata = '0;
            default:     rdata = '0;
        endcase
    end

`ifdef SWIN_IRQ_EN
    logic r_irq;

    // Interrupt follows pending events or overflow one cycle late
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= ~w_empty | r_ovf;
        end
    end

    assign irq = r_irq;
`else
    assign irq = 1'b0;
`endif

endmodule

`default_nettype wire
